// File: rtl/sw_pkt_pkg.sv
// sw_pkt_pkg: packet field widths, bit offsets and pack/unpack helpers shared by SB and Sw users.
package sw_pkt_pkg;

    localparam int NODE_W  = 16;
    localparam int GEN_W   = 12;
    localparam int OPR_W   = 32;
    localparam int PENUM_W = 3;
    localparam int PKT_W   = 1 + NODE_W + GEN_W + OPR_W + 1 + PENUM_W + 1 + 1;

    // Bit offsets, LSB first; lr is the packet MSB.
    localparam int UNI_OPR_LSB = 0;
    localparam int F_MEM_W_LSB = 1;
    localparam int PE_NUM_LSB  = 2;
    localparam int PE_OUT_LSB  = PE_NUM_LSB + PENUM_W;
    localparam int OPR_LSB     = PE_OUT_LSB + 1;
    localparam int GEN_LSB     = OPR_LSB + OPR_W;
    localparam int NODE_LSB    = GEN_LSB + GEN_W;
    localparam int LR_LSB      = NODE_LSB + NODE_W;

    typedef struct packed {
        logic               lr;
        logic [NODE_W-1:0]  node;
        logic [GEN_W-1:0]   gen;
        logic [OPR_W-1:0]   opr;
        logic               pe_out;
        logic [PENUM_W-1:0] pe_num;
        logic               f_mem_w;
        logic               uni_opr;
    } sw_pkt_t;

    function automatic logic [PKT_W-1:0] sw_pack(input sw_pkt_t p);
        return {p.lr, p.node, p.gen, p.opr, p.pe_out, p.pe_num, p.f_mem_w, p.uni_opr};
    endfunction

    function automatic sw_pkt_t sw_unpack(input logic [PKT_W-1:0] v);
        sw_pkt_t p;
        p.lr      = v[LR_LSB];
        p.node    = v[NODE_LSB +: NODE_W];
        p.gen     = v[GEN_LSB +: GEN_W];
        p.opr     = v[OPR_LSB +: OPR_W];
        p.pe_out  = v[PE_OUT_LSB];
        p.pe_num  = v[PE_NUM_LSB +: PENUM_W];
        p.f_mem_w = v[F_MEM_W_LSB];
        p.uni_opr = v[UNI_OPR_LSB];
        return p;
    endfunction

endpackage

// File: rtl/sw_lane_fifo.sv
// sw_lane_fifo: per-lane synchronous FIFO; caller guarantees no push when full and no pop when empty.
module sw_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int PKT_W = 67
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [PKT_W-1:0] din_i,
    output logic [PKT_W-1:0] head_o,
    output logic [PTR_W:0]   fill_o,
    output logic             full_o
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   fill_q;

    assign head_o = mem_q[rd_q];
    assign fill_o = fill_q;
    assign full_o = fill_q == FULL;

    // Pointers are exactly PTR_W bits, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            fill_q <= fill_q + (PTR_W + 1)'(push_i) - (PTR_W + 1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/sw_port_arbiter.sv
// sw_port_arbiter: round-robin share of the single Sw injection port between two SB lanes,
// with a lane FIFO each and a registered output stage that holds under backpressure.
module sw_port_arbiter
    import sw_pkt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid_i_sa,
    input  logic [PKT_W-1:0] in0_pkt_i_sa,
    output logic             in0_ready_o_sa,
    input  logic             in1_valid_i_sa,
    input  logic [PKT_W-1:0] in1_pkt_i_sa,
    output logic             in1_ready_o_sa,
    output logic             out_valid_o_sa,
    output logic [PKT_W-1:0] out_pkt_o_sa,
    output logic             out_src_o_sa,
    input  logic             out_ready_i_sa,
    output logic [PTR_W:0]   fill0_o_sa,
    output logic [PTR_W:0]   fill1_o_sa
);
    logic             full0, full1, push0, push1, pop0, pop1, ne0, ne1, load, gnt;
    logic [PKT_W-1:0] head0, head1, out_pkt_q, out_pkt_d;
    logic             out_valid_q, out_valid_d, out_src_q, out_src_d, last_q, last_d;

    // Ready depends only on registered fill: a same-cycle pop never frees a slot.
    assign in0_ready_o_sa = !full0;
    assign in1_ready_o_sa = !full1;
    assign push0          = in0_valid_i_sa && !full0;
    assign push1          = in1_valid_i_sa && !full1;
    assign ne0            = |fill0_o_sa;
    assign ne1            = |fill1_o_sa;
    assign out_valid_o_sa = out_valid_q;
    assign out_pkt_o_sa   = out_pkt_q;
    assign out_src_o_sa   = out_src_q;

    sw_lane_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PKT_W(PKT_W)) u_fifo0 (
        .clk    (clk),
        .rst    (rst),
        .push_i (push0),
        .pop_i  (pop0),
        .din_i  (in0_pkt_i_sa),
        .head_o (head0),
        .fill_o (fill0_o_sa),
        .full_o (full0)
    );

    sw_lane_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PKT_W(PKT_W)) u_fifo1 (
        .clk    (clk),
        .rst    (rst),
        .push_i (push1),
        .pop_i  (pop1),
        .din_i  (in1_pkt_i_sa),
        .head_o (head1),
        .fill_o (fill1_o_sa),
        .full_o (full1)
    );

    always_comb begin
        load        = (!out_valid_q || out_ready_i_sa) && (ne0 || ne1);
        gnt         = (ne0 && ne1) ? !last_q : ne1;
        pop0        = load && !gnt;
        pop1        = load && gnt;
        out_valid_d = load || (out_valid_q && !out_ready_i_sa);
        out_pkt_d   = load ? (gnt ? head1 : head0) : out_pkt_q;
        out_src_d   = load ? gnt : out_src_q;
        last_d      = load ? gnt : last_q;
    end

    // last_q resets to lane 1 so lane 0 wins the first contended grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            out_src_q   <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

endmodule
